ibex_efpga_ctrl: RTL

EX-stage sequencer for eFPGA custom instructions. It accepts a decoded eFPGA request (enable, operator, operands, delay) and drives the eFPGA fabric port. It then waits for completion, either a fixed cycle count or a done handshake with a timeout. When the result is ready it returns it with a one-cycle `ready_o`, which feeds the ID stage's `ex_ready_i` multicycle wait.

---
 rtl/ibex_efpga_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/ibex_efpga_ctrl.sv
// EX-stage sequencer for eFPGA custom instructions: launches a fabric request,
// waits for a fixed latency or a done handshake (with timeout), returns the result.
module ibex_efpga_ctrl #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_i,
   input  logic [1:0]  operator_i,
   input  logic [31:0] operand_a_i,
   input  logic [31:0] operand_b_i,
   input  logic [3:0]  delay_i,
   input  logic        kill_i,
   output logic        efpga_req_o,
   output logic [1:0]  efpga_operator_o,
   output logic [31:0] efpga_operand_a_o,
   output logic [31:0] efpga_operand_b_o,
   input  logic [31:0] efpga_result_i,
   input  logic        efpga_done_i,
   output logic [31:0] result_o,
   output logic        ready_o,
   output logic        err_o,
   output logic        busy_o
);

   // Bit 0 is a dedicated BUSY flop so the fabric request comes straight off a register.
   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] BUSY = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   logic [1:0] state;
   logic [7:0] cnt;
   logic       hs_mode;
   logic       launch;
   logic       finish;
   logic       timed_out;

   assign launch    = (state == IDLE) & en_i & ~kill_i;
   assign finish    = (state == BUSY) & ~kill_i & ((hs_mode & efpga_done_i) | (cnt == 8'd1));
   // A done arriving on the last counter cycle still counts as success.
   assign timed_out = hs_mode & ~efpga_done_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else if (kill_i) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (en_i) state <= BUSY;
            BUSY:    if (finish) state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt               <= '0;
         hs_mode           <= 1'b0;
         efpga_operator_o  <= '0;
         efpga_operand_a_o <= '0;
         efpga_operand_b_o <= '0;
      end else if (launch) begin
         hs_mode           <= (delay_i == 4'd0);
         cnt               <= (delay_i == 4'd0) ? TIMEOUT_CNT : {4'd0, delay_i};
         efpga_operator_o  <= operator_i;
         efpga_operand_a_o <= operand_a_i;
         efpga_operand_b_o <= operand_b_i;
      end else if ((state == BUSY) && (cnt != 8'd0)) begin
         cnt <= cnt - 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_o <= '0;
         err_o    <= 1'b0;
      end else if (finish) begin
         result_o <= timed_out ? 32'd0 : efpga_result_i;
         err_o    <= timed_out;
      end
   end

   assign efpga_req_o = state[0];
   assign busy_o      = state[0];
   assign ready_o     = state[1] | ((state == IDLE) & ~en_i);

endmodule
